// File: rtl/imem_pkg.sv
// Shared types and constants for the multi-cycle instruction memory.
// Imported by imem_responder and imem_lat_ctr.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [15:0] INSTR_NOP  = 16'h0800;
  localparam logic [15:0] INSTR_HALT = 16'h0000;

  localparam int CTR_BITS = 4;

endpackage

// File: rtl/imem_lat_ctr.sv
// Loadable down-counter timing the BUSY phase; stops at zero.
// last is high while the count is 1, i.e. in the final BUSY cycle.
module imem_lat_ctr
  import imem_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [CTR_BITS-1:0] load_val,
  output logic                last
);

  logic [CTR_BITS-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == CTR_BITS'(1));

endmodule

// File: rtl/imem_responder.sv
// Instruction memory answering fetch reads LATENCY cycles after accept, done for one cycle.
// stall holds fetch while a read is in flight; a side load port preloads the array.
module imem_responder
  import imem_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic [15:0]          addr,
  output logic                 stall,
  output logic                 done,
  output logic [15:0]          instr,
  output logic                 err,
  input  logic                 ld_en,
  input  logic [ADDR_BITS-1:0] ld_addr,
  input  logic [15:0]          ld_data
);

  localparam logic [CTR_BITS-1:0] LOAD_VAL  = CTR_BITS'(LATENCY - 1);
  localparam bit                  ONE_CYCLE = (LATENCY == 1);

  state_t      state;
  state_t      state_nxt;
  logic        accept;
  logic        capture;
  logic        ctr_last;
  logic        out_of_range;
  logic [15:0] addr_q;
  logic [15:0] cap_addr;
  logic [15:0] mem [0:(1<<ADDR_BITS)-1];

  imem_lat_ctr u_lat_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (LOAD_VAL),
    .last     (ctr_last)
  );

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    stall     = 1'b0;
    case (state)
      IDLE, RESP: begin
        stall = req;
        if (req) begin
          accept    = 1'b1;
          state_nxt = ONE_CYCLE ? RESP : BUSY;
        end else begin
          state_nxt = IDLE;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (ctr_last) begin
          state_nxt = RESP;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      stall = 1'b0;
    end
  end

  // With single-cycle latency the capture edge is the accept edge, so read the live address.
  assign capture      = (state_nxt == RESP);
  assign cap_addr     = (state == BUSY) ? addr_q : addr;
  assign out_of_range = ((cap_addr >> ADDR_BITS) != 16'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      done   <= 1'b0;
      err    <= 1'b0;
      instr  <= INSTR_NOP;
      addr_q <= '0;
    end else begin
      state <= state_nxt;
      done  <= capture;
      if (accept) begin
        addr_q <= addr;
      end
      if (capture) begin
        err   <= out_of_range;
        instr <= out_of_range ? INSTR_NOP : mem[cap_addr[ADDR_BITS-1:0]];
      end else begin
        err   <= 1'b0;
      end
    end
  end

  // Array survives reset; a write on the capture edge lands after the read.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Drives LATENCY=4 and LATENCY=1 instances with identical stimulus and checks both
// against a transaction-level model tracking response due cycles and a shadow array.
module tb_imem_responder;
  import imem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [15:0] addr;
  logic        ld_en;
  logic [7:0]  ld_addr;
  logic [15:0] ld_data;

  logic        stall_o [2];
  logic        done_o  [2];
  logic        err_o   [2];
  logic [15:0] instr_o [2];

  always #5 clk = ~clk;

  imem_responder #(.ADDR_BITS(8), .LATENCY(4)) u_lat4 (
    .clk(clk), .rst(rst), .req(req), .addr(addr),
    .stall(stall_o[0]), .done(done_o[0]), .instr(instr_o[0]), .err(err_o[0]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  imem_responder #(.ADDR_BITS(8), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .req(req), .addr(addr),
    .stall(stall_o[1]), .done(done_o[1]), .instr(instr_o[1]), .err(err_o[1]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int          lat      [2] = '{4, 1};
  bit          pend     [2];
  int          due      [2];
  logic [15:0] paddr    [2];
  logic [15:0] exp_ins  [2];
  logic        exp_err  [2];
  logic [15:0] shadow   [256];

  task automatic chk(input string tag, input int lane, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s lane=%0d cyc=%0d got=%h want=%h", tag, lane, cyc, obs, exp);
    end
  endtask

  task automatic check_lane(input int i);
    bit busy, resp_now;
    busy     = pend[i] && (due[i] > cyc);
    resp_now = pend[i] && (due[i] == cyc);
    chk("stall", i, 16'(stall_o[i]), 16'(!rst && (busy || req)));
    chk("done",  i, 16'(done_o[i]),  16'(resp_now));
    chk("err",   i, 16'(err_o[i]),   16'(resp_now && exp_err[i]));
    chk("instr", i, instr_o[i],      exp_ins[i]);
  endtask

  task automatic model_edge(input int i);
    bit busy;
    busy = pend[i] && (due[i] > cyc);
    if (rst) begin
      pend[i]    = 1'b0;
      exp_ins[i] = INSTR_NOP;
      exp_err[i] = 1'b0;
    end else begin
      if (req && !busy) begin
        pend[i]  = 1'b1;
        due[i]   = cyc + lat[i];
        paddr[i] = addr;
      end else if (pend[i] && due[i] == cyc) begin
        pend[i] = 1'b0;
      end
      if (pend[i] && due[i] == cyc + 1) begin
        exp_err[i] = (paddr[i] > 16'd255);
        exp_ins[i] = exp_err[i] ? INSTR_NOP : shadow[paddr[i] % 256];
      end else begin
        exp_err[i] = 1'b0;
      end
    end
  endtask

  task automatic step(input logic r, input logic rq, input logic [15:0] a,
                      input logic le, input logic [7:0] la, input logic [15:0] ld, input bit do_chk);
    @(negedge clk);
    rst = r; req = rq; addr = a; ld_en = le; ld_addr = la; ld_data = ld;
    #1;
    if (do_chk) begin
      for (int i = 0; i < 2; i++) check_lane(i);
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_edge(i);
    if (ld_en) shadow[ld_addr] = ld_data;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 16'h0, 1'b0, 8'h0, 16'h0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; addr = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; due[i] = 0; paddr[i] = '0; exp_ins[i] = INSTR_NOP; exp_err[i] = 1'b0;
    end
    step(1'b1, 1'b0, 16'h0, 1'b0, 8'h0, 16'h0, 1'b0);
    step(1'b1, 1'b1, 16'h0, 1'b0, 8'h0, 16'h0, 1'b1);

    for (int k = 0; k < 256; k++)
      step(1'b0, 1'b0, 16'h0, 1'b1, 8'(k), 16'($urandom), 1'b1);
    step(1'b0, 1'b0, 16'h0, 1'b1, 8'd0, 16'h1234, 1'b1);
    step(1'b0, 1'b0, 16'h0, 1'b1, 8'd1, 16'hABCD, 1'b1);

    // single read of [0]
    step(1'b0, 1'b1, 16'h0000, 1'b0, 8'h0, 16'h0, 1'b1);
    idle(3);
    #1;
    chk("single_done", 0, 16'(done_o[0]), 16'd1);
    chk("single_instr", 0, instr_o[0], 16'h1234);
    idle(2);

    // back-to-back, address changed in the response cycle
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 16'h0000, 1'b0, 8'h0, 16'h0, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 16'h0001, 1'b0, 8'h0, 16'h0, 1'b1);
    #1;
    chk("b2b_second", 0, instr_o[0], 16'hABCD);
    idle(4);

    // out-of-range address
    step(1'b0, 1'b1, 16'h0100, 1'b0, 8'h0, 16'h0, 1'b1);
    idle(3);
    #1;
    chk("oor_err", 0, 16'(err_o[0]), 16'd1);
    chk("oor_instr", 0, instr_o[0], INSTR_NOP);
    idle(2);

    // reset in the middle of a read, then a fresh read
    step(1'b0, 1'b1, 16'h0001, 1'b0, 8'h0, 16'h0, 1'b1);
    step(1'b0, 1'b0, 16'h0001, 1'b0, 8'h0, 16'h0, 1'b1);
    step(1'b1, 1'b0, 16'h0001, 1'b0, 8'h0, 16'h0, 1'b1);
    idle(5);
    step(1'b0, 1'b1, 16'h0001, 1'b0, 8'h0, 16'h0, 1'b1);
    idle(5);

    // load during read: earlier write visible, capture-edge write not
    step(1'b0, 1'b1, 16'h0000, 1'b0, 8'h0, 16'h0, 1'b1);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 8'h0, 16'h5555, 1'b1);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 8'h0, 16'h0, 1'b1);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 8'h0, 16'h7777, 1'b1);
    #1;
    chk("ld_hazard", 0, instr_o[0], 16'h5555);
    idle(3);

    for (int k = 0; k < 1500; k++) begin
      logic        r_rst, r_req, r_le;
      logic [15:0] r_addr;
      r_rst  = ($urandom_range(0, 39) == 0);
      r_req  = ($urandom_range(0, 9) < 7);
      r_addr = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 7));
      r_le   = ($urandom_range(0, 2) == 0);
      step(r_rst, r_req, r_addr, r_le, 8'($urandom_range(0, 7)), 16'($urandom), 1'b1);
    end
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
